fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Byte-serial instruction fetch: assembles 32-bit little-endian words from four
// single-byte memory reads and presents them to decode with a hold/redirect protocol.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_dvalid_i,
  input  logic [7:0]  mem_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [23:0] inst_buf;
  logic [31:0] br_pc;

  assign br_pc = {branch_addr_i[31:2], 2'b00};

  // NOTE: every register here is updated with non-blocking assignments so that
  // all branches read pre-edge values of pc/cnt/state regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      cnt        <= '0;
      inst_buf   <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      if_valid_o <= 1'b0;
      if_inst_o  <= '0;
      if_pc_o    <= '0;
    end else if (rdy) begin
      // Request is dropped unless the next state is REQ.
      mem_req_o <= 1'b0;
      if (branch_flag_i) begin
        pc         <= br_pc;
        cnt        <= '0;
        if_valid_o <= 1'b0;
        // A granted or in-flight byte must still be drained before re-requesting.
        if (state == WAIT || state == FLUSH || (state == REQ && mem_gnt_i)) begin
          state <= FLUSH;
        end else begin
          state      <= REQ;
          mem_req_o  <= 1'b1;
          mem_addr_o <= br_pc;
        end
      end else begin
        case (state)
          IDLE: begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= pc;
          end
          REQ: begin
            if (mem_gnt_i) state <= WAIT;
            else           mem_req_o <= 1'b1;
          end
          WAIT: begin
            if (mem_dvalid_i) begin
              if (cnt == 2'd3) begin
                state      <= DONE;
                cnt        <= '0;
                if_valid_o <= 1'b1;
                if_inst_o  <= {mem_data_i, inst_buf};
                if_pc_o    <= pc;
              end else begin
                case (cnt)
                  2'd0:    inst_buf[7:0]   <= mem_data_i;
                  2'd1:    inst_buf[15:8]  <= mem_data_i;
                  default: inst_buf[23:16] <= mem_data_i;
                endcase
                cnt        <= cnt + 2'd1;
                state      <= REQ;
                mem_req_o  <= 1'b1;
                mem_addr_o <= pc + 32'(cnt) + 32'd1;
              end
            end
          end
          DONE: begin
            if (!stall_i) begin
              pc         <= pc + 32'd4;
              if_valid_o <= 1'b0;
              state      <= REQ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= pc + 32'd4;
            end
          end
          FLUSH: begin
            // The stale byte is swallowed; pc/cnt already point at the redirect target.
            if (mem_dvalid_i) begin
              state      <= REQ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= pc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random traffic,
// all compared against a transaction-level fetch model and a behavioural byte memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_dvalid_i;
  logic [7:0]  mem_data_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .stall_i       (stall_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_dvalid_i  (mem_dvalid_i),
    .mem_data_i    (mem_data_i),
    .if_valid_o    (if_valid_o),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o)
  );

  // Fetch model: started / byte in flight / byte is stale / word held for decode.
  bit          m_started, m_out, m_disc, m_held;
  logic [31:0] m_pc, m_paddr, m_inst, m_ipc;
  logic [1:0]  m_idx;
  logic [7:0]  m_buf [4];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req();
    return m_started && !m_held && !m_out;
  endfunction

  task automatic check_all();
    chk("mem_req", 32'(mem_req_o), 32'(exp_req()));
    chk("if_valid", 32'(if_valid_o), 32'(m_held));
    if (exp_req()) chk("mem_addr", mem_addr_o, m_pc + 32'(m_idx));
    if (m_held) begin
      chk("if_inst", if_inst_o, m_inst);
      chk("if_pc", if_pc_o, m_ipc);
    end
  endtask

  task automatic model_update(input bit br, input logic [31:0] ba, input bit g,
                              input bit dv, input bit st);
    bit req_now;
    req_now = exp_req();
    if (br) begin
      if (req_now && g) begin
        m_out   = 1'b1;
        m_paddr = m_pc + 32'(m_idx);
      end
      if (m_out) m_disc = 1'b1;
      m_pc      = ba & 32'hFFFF_FFFC;
      m_idx     = 2'd0;
      m_held    = 1'b0;
      m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held) begin
      if (!st) begin
        m_held = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
    end else if (m_out) begin
      if (dv) begin
        m_out = 1'b0;
        if (m_disc) begin
          m_disc = 1'b0;
        end else begin
          m_buf[m_idx] = mem_byte(m_paddr);
          if (m_idx == 2'd3) begin
            m_held = 1'b1;
            m_inst = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            m_ipc  = m_pc;
            m_idx  = 2'd0;
          end else begin
            m_idx = m_idx + 2'd1;
          end
        end
      end
    end else if (g) begin
      m_out   = 1'b1;
      m_paddr = m_pc + 32'(m_idx);
    end
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, advance model, move to next falling edge.
  task automatic step(input bit r, input bit br, input logic [31:0] ba, input bit g,
                      input bit dv_en, input bit st);
    bit dv;
    check_all();
    if (m_out) dv = dv_en && !(br && r);
    else       dv = exp_req() && dv_en && 1'($urandom);
    rdy           = r;
    branch_flag_i = br;
    branch_addr_i = ba;
    mem_gnt_i     = g;
    stall_i       = st;
    mem_dvalid_i  = dv;
    mem_data_i    = (dv && m_out) ? mem_byte(m_paddr) : 8'($urandom);
    if (r) model_update(br, ba, g, dv && m_out, st);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    rdy           = 1'($urandom);
    branch_flag_i = 1'($urandom);
    branch_addr_i = $urandom;
    mem_gnt_i     = 1'($urandom);
    mem_dvalid_i  = 1'($urandom);
    mem_data_i    = 8'($urandom);
    stall_i       = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_if_valid", 32'(if_valid_o), 32'd0);
    chk("rst_if_inst", if_inst_o, 32'd0);
    chk("rst_if_pc", if_pc_o, 32'd0);
    m_started = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_held = 1'b0;
    m_pc = '0; m_idx = '0; m_inst = '0; m_ipc = '0; m_paddr = '0;
    rst = 1'b0;
  endtask

  // Zero-wait memory with decode stalled; returns cycles until the word is presented.
  task automatic run_zero_wait(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
      cycles++;
      if (if_valid_o) break;
    end
    chk("fetch_completes", 32'(if_valid_o), 32'd1);
  endtask

  initial begin
    int t;
    @(negedge clk);
    do_reset();

    // Zero-wait first fetch: valid 9 cycles after release, 8 after first request.
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("first_req", 32'(mem_req_o), 32'd1);
    chk("first_addr", mem_addr_o, 32'd0);
    run_zero_wait(t);
    chk("req_to_valid", 32'(t), 32'd8);
    chk("inst_word0", if_inst_o, 32'h0010_0513);
    chk("pc_word0", if_pc_o, 32'd0);

    // Stall holds the word; release requests pc+4; next word 9 cycles later.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("stall_hold_inst", if_inst_o, 32'h0010_0513);
    end
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("after_stall_addr", mem_addr_o, 32'd4);
    run_zero_wait(t);
    chk("back_to_back", 32'(t + 1), 32'd9);

    // Grant withheld three cycles: request and address stay put.
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("nogrant_addr", mem_addr_o, 32'd8);
    end
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("grant_taken", 32'(mem_req_o), 32'd0);

    // Branch while waiting for byte 2: flush, discard late byte, refetch aligned target.
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_1007, 1'b0, 1'b0, 1'b0);
    chk("flush_no_req", 32'(mem_req_o), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("redirect_addr", mem_addr_o, 32'h0000_1004);
    chk("no_old_valid", 32'(if_valid_o), 32'd0);
    run_zero_wait(t);
    chk("redirect_pc", if_pc_o, 32'h0000_1004);

    // Top-of-memory word, then wrap to zero; rdy low mid-wait freezes everything.
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    chk("top_addr", mem_addr_o, 32'hFFFF_FFFC);
    run_zero_wait(t);
    chk("top_pc", if_pc_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_addr", mem_addr_o, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'($urandom));
    run_zero_wait(t);
    chk("resume_inst", if_inst_o, 32'h0010_0513);
    chk("resume_pc", if_pc_o, 32'd0);

    // Reset while a byte is in flight: first request afterwards is address 0.
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_addr", mem_addr_o, 32'd0);
    chk("post_rst_req", 32'(mem_req_o), 32'd1);

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] ba;
      ba = 1'($urandom) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
      step(($urandom % 8) != 0, ($urandom % 16) == 0, ba,
           1'($urandom), 1'($urandom), ($urandom % 3) == 0);
    end
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
